test_ram_boot: RTL and testbench
================================

// Module: test_ram_boot
// PURPOSE
//  Parametrised single-port test memory for the CPU test harness: word-wide array with byte enables,
//  a request/ready/rvalid handshake and a sequenced boot loader that rewrites the whole array after reset.
//  Boot image = fixed test program (words 0..BOOT_LEN-1); all other words cleared to 0.
//  A parametrised tap window exports TAP_CNT consecutive words from TAP_BASE for result checking.
// PARAMETERS
//  DATA_W    16  word width; multiple of 8
//  ADDR_W    15  address port width
//  DEPTH     64  implemented words; legal addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W
//  BOOT_LEN  11  boot-image words loaded at 0..BOOT_LEN-1; BOOT_LEN <= DEPTH
//  TAP_BASE  16  first word of tap window
//  TAP_CNT   5   tap window length; TAP_BASE+TAP_CNT <= DEPTH
// PORTS
//  test_clk        in   1              clock, all logic on rising edge
//  test_rst        in   1              synchronous, active-high reset
//  mem_test_req    in   1              access request, sampled when mem_test_ready=1
//  mem_test_we     in   1              1=write, 0=read
//  mem_test_be     in   DATA_W/8       byte enables for writes (bit i -> bits 8i+7:8i)
//  mem_test_addr   in   ADDR_W         word address
//  mem_test_wdata  in   DATA_W         write data
//  mem_test_ready  out  1              1 when accesses are accepted (init done)
//  mem_test_rvalid out  1              one-cycle pulse: read data valid
//  mem_test_rdata  out  DATA_W         read data, held until next read completes
//  mem_test_err    out  1              one-cycle pulse with rvalid/write-ack: address >= DEPTH
//  init_done       out  1              level; boot load complete
//  mem_tap_data    out  TAP_CNT*DATA_W word TAP_BASE+k on bits k*DATA_W +: DATA_W
// BEHAVIOUR
//  Reset (test_rst=1 at edge): state<=INIT, load pointer<=0; ready, rvalid, err, init_done <= 0; rdata <= 0.
//  FSM INIT: one word per cycle at pointer p: boot_word(p) if p<BOOT_LEN else 0; p++.
//    After writing p=DEPTH-1 -> RUN; init_done=1 and ready=1 from the next cycle on.
//    Total: first access accepted exactly DEPTH cycles after the first cycle with test_rst=0.
//  INIT: ready=0; req ignored entirely (no write, no rvalid, no err).
//  RUN: ready=1 constantly; one access per cycle, no back-pressure.
//    Write accepted at edge N: bytes with be=1 updated at edge N; be=0 bytes retain. No rvalid.
//    Read accepted at edge N: rdata updated and rvalid=1 for the cycle after edge N (latency 1);
//      back-to-back reads give rvalid every cycle.
//    addr >= DEPTH: write dropped; read returns rdata=0; err=1 in the same cycle rvalid would pulse
//      (for writes: cycle after acceptance). Upper address bits never alias.
//    be=0 on write: legal no-op, no err.
//  Taps: combinational from array; a write to a tap word is visible the cycle after its accept edge.
//  Reset asserted mid-INIT or mid-RUN: loader restarts at p=0, full image reloaded; pending rvalid dropped.
//  Reset has priority over any request in the same cycle.
//  Pointer width = clog2(DEPTH)+1; no wrap-around of pointer before INIT exits.
// STRUCTURE
//  Package test_ram_pkg: state encoding (INIT, RUN), BOOT_IMAGE constants
//    {380a,8300,ab00,a600,9200,a200,ca00,5300,fb00,0003,0010}, tap-window helper function.
//  Sub-module test_ram_boot_rom: combinational addr -> boot word (0 beyond image).
//  Top: loader FSM + pointer, access decode/range check, byte-masked write mux, read register, tap wiring.
// TESTING
//  1 Release reset, count cycles -> ready/init_done rise after exactly 64 cycles; read 0 -> 380a, 9 -> 0003, 10 -> 0010, 11 -> 0000, 63 -> 0000.
//  2 RUN: write 0x1234 be=2'b10 to addr 16 -> tap word 0 = 0x1200 next cycle; read 16 -> rvalid, rdata=0x1200.
//  3 Read addr 64 -> rvalid=1, err=1, rdata=0; write 0xffff to addr 0x7fff -> err pulse, array unchanged (addr 63 still 0).
//  4 Reset pulse at cycle 30 of INIT -> ready stays 0, init_done rises 64 cycles after release; addr 0 re-reads 380a.
//  5 Overwrite addr 0 with 0xdead in RUN, then reset -> after init addr 0 reads 380a again.
//  6 Five back-to-back reads addr 0..4 -> rvalid high 5 consecutive cycles, data 380a,8300,ab00,a600,9200; req during INIT -> no rvalid/err.

Source files
------------

// File: rtl/test_ram_pkg.sv
// Shared definitions for the boot-loaded test RAM: loader state encoding,
// the fixed boot program and tap-window bit placement.
package test_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int BOOT_IMAGE_LEN = 11;

  localparam logic [15:0] BOOT_IMAGE [BOOT_IMAGE_LEN] = '{
    16'h380a, 16'h8300, 16'hab00, 16'ha600, 16'h9200, 16'ha200,
    16'hca00, 16'h5300, 16'hfb00, 16'h0003, 16'h0010
  };

  // Bit offset of tap word k inside the flattened tap bus.
  function automatic int tap_lsb(input int k, input int word_w);
    return k * word_w;
  endfunction

endpackage

// File: rtl/test_ram_boot_if.sv
// Request/ready/rvalid access bus of the test RAM; master drives requests,
// slave (the memory) returns ready, read data and error pulses.
interface test_ram_boot_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);

  logic                  mem_test_req;
  logic                  mem_test_we;
  logic [DATA_W/8-1:0]   mem_test_be;
  logic [ADDR_W-1:0]     mem_test_addr;
  logic [DATA_W-1:0]     mem_test_wdata;
  logic                  mem_test_ready;
  logic                  mem_test_rvalid;
  logic [DATA_W-1:0]     mem_test_rdata;
  logic                  mem_test_err;

  modport master (
    output mem_test_req, mem_test_we, mem_test_be, mem_test_addr, mem_test_wdata,
    input  mem_test_ready, mem_test_rvalid, mem_test_rdata, mem_test_err
  );

  modport slave (
    input  mem_test_req, mem_test_we, mem_test_be, mem_test_addr, mem_test_wdata,
    output mem_test_ready, mem_test_rvalid, mem_test_rdata, mem_test_err
  );

endinterface

// File: rtl/test_ram_boot_rom.sv
// Combinational boot-image lookup: returns the program word for a loader
// pointer value, zero for every location beyond the image.
module test_ram_boot_rom
  import test_ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PTR_W    = 7,
  parameter int BOOT_LEN = 11
) (
  input  logic [PTR_W-1:0]  addr_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < BOOT_IMAGE_LEN; i++) begin
      if ((i < BOOT_LEN) && (addr_i == PTR_W'(i))) begin
        word_o = DATA_W'(BOOT_IMAGE[i]);
      end
    end
  end

endmodule

// File: rtl/test_ram_boot.sv
// Single-port test RAM with byte enables, a one-word-per-cycle boot loader
// that rewrites the whole array after every reset, and a result tap window.
module test_ram_boot
  import test_ram_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int DEPTH    = 64,
  parameter int BOOT_LEN = 11,
  parameter int TAP_BASE = 16,
  parameter int TAP_CNT  = 5
) (
  input  logic                      test_clk,
  input  logic                      test_rst,
  test_ram_boot_if.slave            mem,
  output logic                      init_done,
  output logic [TAP_CNT*DATA_W-1:0] mem_tap_data
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = $clog2(DEPTH) + 1;

  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  // Loader state
  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               load_en;
  logic [DATA_W-1:0]  boot_word;

  // Storage and write port
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  wr_data;
  logic [NBYTES-1:0]  wr_be;

  // Access decode and read register
  logic               run;
  logic               acc;
  logic               rd_acc;
  logic               addr_ok;
  logic [IDX_W-1:0]   acc_idx;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  test_ram_boot_rom #(
    .DATA_W   (DATA_W),
    .PTR_W    (PTR_W),
    .BOOT_LEN (BOOT_LEN)
  ) u_rom (
    .addr_i (ptr_q),
    .word_o (boot_word)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load_en = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        load_en = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge test_clk) begin
    if (test_rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign run     = (state_q == ST_RUN);
  assign acc     = run && mem.mem_test_req;
  assign rd_acc  = acc && !mem.mem_test_we;
  // Full-width compare so out-of-range upper address bits never alias.
  assign addr_ok = ({1'b0, mem.mem_test_addr} < DEPTH_A);
  assign acc_idx = mem.mem_test_addr[IDX_W-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr_q[IDX_W-1:0];
    wr_data = boot_word;
    wr_be   = '1;
    if (load_en) begin
      wr_en = 1'b1;
    end else if (acc && mem.mem_test_we && addr_ok) begin
      wr_en   = 1'b1;
      wr_idx  = acc_idx;
      wr_data = mem.mem_test_wdata;
      wr_be   = mem.mem_test_be;
    end
  end

  // Array is data only: it is not cleared by reset, the loader rewrites it.
  always_ff @(posedge test_clk) begin
    if (!test_rst && wr_en) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    rvalid_d = rd_acc;
    err_d    = acc && !addr_ok;
    rdata_d  = rdata_q;
    if (rd_acc) begin
      rdata_d = addr_ok ? mem_q[acc_idx] : '0;
    end
  end

  // Read response stage: one cycle after the accept edge
  always_ff @(posedge test_clk) begin
    if (test_rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem.mem_test_ready  = run;
  assign mem.mem_test_rvalid = rvalid_q;
  assign mem.mem_test_rdata  = rdata_q;
  assign mem.mem_test_err    = err_q;
  assign init_done           = run;

  for (genvar k = 0; k < TAP_CNT; k++) begin : g_tap
    assign mem_tap_data[tap_lsb(k, DATA_W) +: DATA_W] = mem_q[IDX_W'(TAP_BASE + k)];
  end

endmodule

// File: tb/tb_test_ram_boot.sv
// Scoreboard bench for test_ram_boot: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever rvalid or err is seen.
module tb_test_ram_boot;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int TAP_CNT = 5;

  typedef struct {
    logic        rv;
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic init_done;
  logic [TAP_CNT*DATA_W-1:0] taps;

  int vectors;
  int miscompares;

  exp_t  sb[$];
  string sb_nm[$];

  test_ram_boot_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  test_ram_boot #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(64),
    .BOOT_LEN(11), .TAP_BASE(16), .TAP_CNT(TAP_CNT)
  ) dut (
    .test_clk     (clk),
    .test_rst     (rst),
    .mem          (mem_if),
    .init_done    (init_done),
    .mem_tap_data (taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (mem_if.mem_test_rvalid || mem_if.mem_test_err) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got rvalid=%b err=%b rdata=%h expected no response",
                 mem_if.mem_test_rvalid, mem_if.mem_test_err, mem_if.mem_test_rdata);
      end else begin
        exp_t  e;
        string nm;
        e  = sb.pop_front();
        nm = sb_nm.pop_front();
        if (mem_if.mem_test_rvalid !== e.rv || mem_if.mem_test_err !== e.err ||
            (e.rv && mem_if.mem_test_rdata !== e.data)) begin
          miscompares++;
          $display("FAIL %s: got rvalid=%b err=%b rdata=%h expected rvalid=%b err=%b rdata=%h",
                   nm, mem_if.mem_test_rvalid, mem_if.mem_test_err, mem_if.mem_test_rdata,
                   e.rv, e.err, e.data);
        end
      end
    end
  end

  task automatic push(input string nm, input logic rv, input logic er, input logic [15:0] d);
    exp_t e;
    e.rv = rv; e.err = er; e.data = d;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic do_read(input string nm, input logic [14:0] a, input logic [15:0] d,
                         input logic er);
    push(nm, 1'b1, er, d);
    mem_if.mem_test_req  = 1'b1;
    mem_if.mem_test_we   = 1'b0;
    mem_if.mem_test_addr = a;
    @(posedge clk); #1;
    mem_if.mem_test_req  = 1'b0;
  endtask

  task automatic do_write(input string nm, input logic [14:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic er);
    if (er) push(nm, 1'b0, 1'b1, 16'h0000);
    mem_if.mem_test_req   = 1'b1;
    mem_if.mem_test_we    = 1'b1;
    mem_if.mem_test_addr  = a;
    mem_if.mem_test_wdata = d;
    mem_if.mem_test_be    = be;
    @(posedge clk); #1;
    mem_if.mem_test_req   = 1'b0;
    mem_if.mem_test_we    = 1'b0;
  endtask

  task automatic drain(input string nm);
    @(negedge clk);
    @(negedge clk);
    check(nm, 80'(sb.size()), 80'd0);
  endtask

  // Releases reset and counts edges until ready; optionally hammers req meanwhile.
  task automatic release_and_wait(input string nm, input bit poke);
    int cyc;
    int viol;
    cyc  = 0;
    viol = 0;
    rst  = 1'b0;
    if (poke) begin
      mem_if.mem_test_req   = 1'b1;
      mem_if.mem_test_addr  = 15'd0;
      mem_if.mem_test_wdata = 16'hdead;
      mem_if.mem_test_be    = 2'b11;
    end
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) mem_if.mem_test_we = ~mem_if.mem_test_we;
      if (mem_if.mem_test_rvalid || mem_if.mem_test_err) viol++;
      if (mem_if.mem_test_ready || cyc >= 200) break;
    end
    mem_if.mem_test_req = 1'b0;
    mem_if.mem_test_we  = 1'b0;
    check({nm, "_cycles"}, 80'(cyc), 80'd64);
    check({nm, "_init_done"}, 80'(init_done), 80'd1);
    check({nm, "_idle"}, 80'(viol), 80'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    mem_if.mem_test_req   = 1'b0;
    mem_if.mem_test_we    = 1'b0;
    mem_if.mem_test_be    = 2'b00;
    mem_if.mem_test_addr  = '0;
    mem_if.mem_test_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  80'(mem_if.mem_test_ready),  80'd0);
    check("rst_done",   80'(init_done),              80'd0);
    check("rst_rvalid", 80'(mem_if.mem_test_rvalid), 80'd0);
    check("rst_err",    80'(mem_if.mem_test_err),    80'd0);
    check("rst_rdata",  80'(mem_if.mem_test_rdata),  80'd0);

    // 1: boot image and cleared words
    release_and_wait("boot1", 1'b0);
    check("taps_cleared", taps, 80'd0);
    do_read("rd0",  15'd0,  16'h380a, 1'b0);
    do_read("rd9",  15'd9,  16'h0003, 1'b0);
    do_read("rd10", 15'd10, 16'h0010, 1'b0);
    do_read("rd11", 15'd11, 16'h0000, 1'b0);
    do_read("rd63", 15'd63, 16'h0000, 1'b0);
    drain("drain1");

    // 2: byte-masked write into the tap window
    do_write("wr16", 15'd16, 16'h1234, 2'b10, 1'b0);
    check("tap0_upper", 80'(taps[15:0]), 80'h1200);
    do_write("wr17_be0", 15'd17, 16'hffff, 2'b00, 1'b0);
    check("tap1_be0", 80'(taps[31:16]), 80'h0000);
    do_read("rd16", 15'd16, 16'h1200, 1'b0);
    drain("drain2");

    // 3: out-of-range accesses
    do_read("rd64_err", 15'd64, 16'h0000, 1'b1);
    do_write("wr7fff_err", 15'h7fff, 16'hffff, 2'b11, 1'b1);
    do_read("rd63_after", 15'd63, 16'h0000, 1'b0);
    drain("drain3");

    // 4: reset mid-INIT, requests during INIT ignored
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      int early;
      early = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (mem_if.mem_test_ready) early++;
      end
      check("init30_ready", 80'(early), 80'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    release_and_wait("boot4", 1'b1);
    do_read("rd0_reboot", 15'd0, 16'h380a, 1'b0);
    drain("drain4");

    // 5: overwrite then reset restores the image; reset beats a read
    do_write("wr0", 15'd0, 16'hdead, 2'b11, 1'b0);
    do_read("rd0_dead", 15'd0, 16'hdead, 1'b0);
    rst = 1'b1;
    mem_if.mem_test_req  = 1'b1;
    mem_if.mem_test_we   = 1'b0;
    mem_if.mem_test_addr = 15'd1;
    @(posedge clk); #1;
    mem_if.mem_test_req = 1'b0;
    check("rst_vs_req_rvalid", 80'(mem_if.mem_test_rvalid), 80'd0);
    release_and_wait("boot5", 1'b0);
    do_read("rd0_restored", 15'd0, 16'h380a, 1'b0);
    drain("drain5");

    // 6: back-to-back reads
    begin
      logic [15:0] img [5];
      img = '{16'h380a, 16'h8300, 16'hab00, 16'ha600, 16'h9200};
      for (int i = 0; i < 5; i++) begin
        push($sformatf("b2b%0d", i), 1'b1, 1'b0, img[i]);
        mem_if.mem_test_req  = 1'b1;
        mem_if.mem_test_we   = 1'b0;
        mem_if.mem_test_addr = 15'(i);
        @(posedge clk); #1;
        check($sformatf("b2b_rvalid%0d", i), 80'(mem_if.mem_test_rvalid), 80'd1);
      end
      mem_if.mem_test_req = 1'b0;
    end
    drain("drain6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
